cp0_regfile_timer: RTL and testbench

Parametrised coprocessor-0 register file for the MIPS core. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and generates the timer interrupt. It samples external hardware interrupt lines and produces a single interrupt-pending request for the writeback/exception logic. It sits beside the WB stage: mtc0 writes, exception commits and eret commits arrive from WB, and mfc0 reads are served combinationally.

---
 rtl/cp0_regfile_timer.sv | 199 +++++++++++++++++++
 tb/tb_cp0_regfile_timer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile_timer.sv
// Coprocessor-0 register file with the Count/Compare timer interrupt.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. mtc0, exception and
// eret commits arrive from WB. mfc0 reads and interrupt_pending are
// combinational from registered state.
module cp0_regfile_timer #(
   parameter int HW_INT_COUNT = 6,
   parameter int COUNT_DIV    = 2,
   parameter int TIMER_ENABLE = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4:0]              read_register,
   input  logic [2:0]              read_select,
   output logic [31:0]             read_data,
   input  logic                    write_enable,
   input  logic [4:0]              write_register,
   input  logic [2:0]              write_select,
   input  logic [31:0]             write_data,
   input  logic                    exception_valid,
   input  logic [4:0]              exception_code,
   input  logic [31:0]             exception_pc,
   input  logic                    in_delay_slot,
   input  logic                    bad_vaddr_valid,
   input  logic [31:0]             bad_vaddr,
   input  logic                    eret,
   input  logic [HW_INT_COUNT-1:0] hw_interrupt,
   output logic                    interrupt_pending,
   output logic [31:0]             epc,
   output logic                    status_exl
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   // A divider of 1 still needs a 1-bit tick counter; it simply wraps every cycle.
   localparam int              TICK_W   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(COUNT_DIV - 1);

   logic [31:0]             badvaddr_q, badvaddr_d;
   logic [31:0]             count_q, count_d;
   logic [31:0]             compare_q, compare_d;
   logic [31:0]             epc_q, epc_d;
   logic [7:0]              im_q, im_d;
   logic                    exl_q, exl_d;
   logic                    ie_q, ie_d;
   logic                    bd_q, bd_d;
   logic                    ti_q, ti_d;
   logic [1:0]              sw_ip_q, sw_ip_d;
   logic [4:0]              exc_code_q, exc_code_d;
   logic [HW_INT_COUNT-1:0] hw_ip_q, hw_ip_d;
   logic [TICK_W-1:0]       tick_q, tick_d;

   logic [5:0]  hw_pad;
   logic [7:0]  cause_ip;
   logic        wr_sel0, wr_status, wr_cause, wr_epc, wr_count, wr_compare;
   logic        tick_wrap;

   assign wr_sel0    = write_enable && (write_select == 3'd0);
   assign wr_status  = wr_sel0 && (write_register == REG_STATUS);
   assign wr_cause   = wr_sel0 && (write_register == REG_CAUSE);
   assign wr_epc     = wr_sel0 && (write_register == REG_EPC);
   assign wr_count   = wr_sel0 && (write_register == REG_COUNT);
   assign wr_compare = wr_sel0 && (write_register == REG_COMPARE);
   assign tick_wrap  = (tick_q == TICK_MAX);

   // Cause.IP assembly: line 5 shares IP[7] with the timer interrupt.
   always_comb begin
      hw_pad = '0;
      hw_pad[HW_INT_COUNT-1:0] = hw_ip_q;
      cause_ip = {ti_q | hw_pad[5], hw_pad[4:0], sw_ip_q};
   end

   assign interrupt_pending = ie_q && !exl_q && |(cause_ip & im_q);
   assign epc               = epc_q;
   assign status_exl        = exl_q;

   // mfc0 read mux; unmapped register/select combinations read 0.
   always_comb begin
      read_data = '0;
      if (read_select == 3'd0) begin
         case (read_register)
            REG_BADVADDR: read_data = badvaddr_q;
            REG_COUNT:    read_data = count_q;
            REG_COMPARE:  read_data = compare_q;
            REG_STATUS:   read_data = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
            REG_CAUSE:    read_data = {bd_q, ti_q, 14'd0, cause_ip, 1'b0, exc_code_q, 2'b00};
            REG_EPC:      read_data = epc_q;
            default:      read_data = '0;
         endcase
      end
   end

   // Next-state: exception > eret > mtc0 for EXL; EPC/BD only captured outside EXL.
   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      sw_ip_d    = sw_ip_q;
      exc_code_d = exc_code_q;
      hw_ip_d    = hw_interrupt;
      tick_d     = tick_q;

      if (exception_valid) begin
         exc_code_d = exception_code;
         exl_d      = 1'b1;
         if (bad_vaddr_valid) begin
            badvaddr_d = bad_vaddr;
         end
         if (!exl_q) begin
            bd_d  = in_delay_slot;
            epc_d = in_delay_slot ? (exception_pc - 32'd4) : exception_pc;
         end
      end else if (eret) begin
         exl_d = 1'b0;
      end else if (wr_status) begin
         exl_d = write_data[1];
      end

      if (wr_status) begin
         im_d = write_data[15:8];
         ie_d = write_data[0];
      end
      if (wr_cause) begin
         sw_ip_d = write_data[9:8];
      end
      if (wr_epc && !exception_valid) begin
         epc_d = write_data;
      end

      // A Count write restarts the divider and suppresses the pending increment.
      if (wr_count) begin
         count_d = write_data;
         tick_d  = '0;
      end else begin
         tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
         if (tick_wrap) begin
            count_d = count_q + 32'd1;
            if ((count_q + 32'd1) == compare_q) begin
               ti_d = 1'b1;
            end
         end
      end
      if (wr_compare) begin
         compare_d = write_data;
         ti_d      = 1'b0;
      end

      if (TIMER_ENABLE == 0) begin
         count_d   = '0;
         compare_d = '0;
         ti_d      = 1'b0;
         tick_d    = '0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         sw_ip_q    <= '0;
         exc_code_q <= '0;
         hw_ip_q    <= '0;
         tick_q     <= '0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         sw_ip_q    <= sw_ip_d;
         exc_code_q <= exc_code_d;
         hw_ip_q    <= hw_ip_d;
         tick_q     <= tick_d;
      end
   end

endmodule

// File: tb/tb_cp0_regfile_timer.sv
// Bench for cp0_regfile_timer: directed stimulus, a behavioural CP0 model
// checked every cycle, and literal spot checks of key values.
module tb_cp0_regfile_timer;

   localparam int HW  = 2;
   localparam int DIV = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    read_register = '0;
   logic [2:0]    read_select = '0;
   logic [31:0]   read_data;
   logic          write_enable = 1'b0;
   logic [4:0]    write_register = '0;
   logic [2:0]    write_select = '0;
   logic [31:0]   write_data = '0;
   logic          exception_valid = 1'b0;
   logic [4:0]    exception_code = '0;
   logic [31:0]   exception_pc = '0;
   logic          in_delay_slot = 1'b0;
   logic          bad_vaddr_valid = 1'b0;
   logic [31:0]   bad_vaddr = '0;
   logic          eret = 1'b0;
   logic [HW-1:0] hw_interrupt = '0;
   logic          interrupt_pending;
   logic [31:0]   epc;
   logic          status_exl;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   cp0_regfile_timer #(.HW_INT_COUNT(HW), .COUNT_DIV(DIV), .TIMER_ENABLE(1)) dut (
      .clock(clock), .reset(reset),
      .read_register(read_register), .read_select(read_select), .read_data(read_data),
      .write_enable(write_enable), .write_register(write_register),
      .write_select(write_select), .write_data(write_data),
      .exception_valid(exception_valid), .exception_code(exception_code),
      .exception_pc(exception_pc), .in_delay_slot(in_delay_slot),
      .bad_vaddr_valid(bad_vaddr_valid), .bad_vaddr(bad_vaddr), .eret(eret),
      .hw_interrupt(hw_interrupt), .interrupt_pending(interrupt_pending),
      .epc(epc), .status_exl(status_exl)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   bit          m_valid = 0;
   logic [31:0] m_badv, m_load, m_cmp, m_epc;
   int unsigned m_elapsed;
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti;
   logic [1:0]  m_swip;
   logic [4:0]  m_exc;
   logic [HW-1:0] m_hw;

   function automatic logic [31:0] m_count();
      return m_load + 32'(m_elapsed / DIV);
   endfunction

   function automatic logic [7:0] m_ip();
      logic [7:0] ip;
      ip = {6'd0, m_swip};
      for (int i = 0; i < HW; i++) ip[2+i] = ip[2+i] | m_hw[i];
      ip[7] = ip[7] | m_ti;
      return ip;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
      if (s != 3'd0) return 32'd0;
      case (r)
         5'd8:  return m_badv;
         5'd9:  return m_count();
         5'd11: return m_cmp;
         5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
         5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
         5'd14: return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_pending();
      return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
   endfunction

   always @(posedge clock) begin
      logic        wr, o_exl;
      logic [31:0] o_cmp;
      if (reset) begin
         m_badv = 0; m_load = 0; m_cmp = 0; m_epc = 0; m_elapsed = 0;
         m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_swip = 0;
         m_exc = 0; m_hw = 0; m_valid = 1;
      end else begin
         o_exl = m_exl;
         o_cmp = m_cmp;
         wr = write_enable && (write_select == 3'd0);
         if (exception_valid) begin
            m_exc = exception_code;
            if (bad_vaddr_valid) m_badv = bad_vaddr;
            if (!o_exl) begin
               m_bd  = in_delay_slot;
               m_epc = in_delay_slot ? exception_pc - 32'd4 : exception_pc;
            end
            m_exl = 1;
         end else if (eret) begin
            m_exl = 0;
         end
         if (wr && write_register == 5'd12) begin
            m_im = write_data[15:8];
            m_ie = write_data[0];
            if (!exception_valid && !eret) m_exl = write_data[1];
         end
         if (wr && write_register == 5'd13) m_swip = write_data[9:8];
         if (wr && write_register == 5'd14 && !exception_valid) m_epc = write_data;
         if (wr && write_register == 5'd9) begin
            m_load = write_data;
            m_elapsed = 0;
         end else begin
            m_elapsed++;
            if ((m_elapsed % DIV) == 0 && m_count() == o_cmp) m_ti = 1;
         end
         if (wr && write_register == 5'd11) begin
            m_cmp = write_data;
            m_ti = 0;
         end
         m_hw = hw_interrupt;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clock) begin
      if (m_valid) begin
         check($sformatf("read r%0d s%0d", read_register, read_select),
               read_data, m_read(read_register, read_select));
         check("interrupt_pending", 32'(interrupt_pending), 32'(m_pending()));
         check("epc", epc, m_epc);
         check("status_exl", 32'(status_exl), 32'(m_exl));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      case (cyc % 8)
         0: begin read_register = 5'd8;  read_select = 3'd0; end
         1: begin read_register = 5'd9;  read_select = 3'd0; end
         2: begin read_register = 5'd11; read_select = 3'd0; end
         3: begin read_register = 5'd12; read_select = 3'd0; end
         4: begin read_register = 5'd13; read_select = 3'd0; end
         5: begin read_register = 5'd14; read_select = 3'd0; end
         6: begin read_register = 5'd9;  read_select = 3'd1; end
         default: begin read_register = 5'd15; read_select = 3'd0; end
      endcase
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      write_enable = 1; write_register = r; write_select = 0; write_data = d;
      step();
      write_enable = 0;
   endtask

   task automatic take_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                           input logic bvv, input logic [31:0] bv, input logic er);
      exception_valid = 1; exception_code = code; exception_pc = pc;
      in_delay_slot = ds; bad_vaddr_valid = bvv; bad_vaddr = bv; eret = er;
      step();
      exception_valid = 0; in_delay_slot = 0; bad_vaddr_valid = 0; eret = 0;
   endtask

   task automatic do_eret();
      eret = 1;
      step();
      eret = 0;
   endtask

   task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string name);
      read_register = r; read_select = 0;
      #1;
      check(name, read_data, exp);
   endtask

   initial begin
      reset = 1;
      step(); step();
      reset = 0;
      peek(5'd12, 32'h0040_0000, "reset status");
      peek(5'd13, 32'h0, "reset cause");
      peek(5'd14, 32'h0, "reset epc reg");
      peek(5'd9,  32'h0, "reset count");
      peek(5'd11, 32'h0, "reset compare");
      check("reset pending", 32'(interrupt_pending), 32'h0);
      check("reset exl", 32'(status_exl), 32'h0);
      for (int i = 0; i < 10; i++) step();
      peek(5'd9, 32'd5, "count after 10 cycles");

      // Timer interrupt set, enabled, then cleared by Compare write.
      mtc0(5'd11, 32'd8);
      mtc0(5'd9, 32'd6);
      for (int i = 0; i < 4; i++) step();
      peek(5'd13, 32'h4000_8000, "cause TI set");
      check("pending masked", 32'(interrupt_pending), 32'h0);
      mtc0(5'd12, 32'h0000_8001);
      check("pending TI", 32'(interrupt_pending), 32'h1);
      peek(5'd12, 32'h0040_8001, "status IM/IE");
      mtc0(5'd11, 32'h20);
      peek(5'd13, 32'h0, "cause TI cleared");
      check("pending cleared", 32'(interrupt_pending), 32'h0);

      // Exceptions and eret.
      reset = 1; step(); reset = 0;
      take_exc(5'h04, 32'hBFC0_0104, 1'b1, 1'b1, 32'h13, 1'b0);
      peek(5'd14, 32'hBFC0_0100, "epc delay slot");
      peek(5'd13, 32'h8000_0010, "cause BD/ExcCode");
      peek(5'd8,  32'h13, "badvaddr");
      check("exl after exc", 32'(status_exl), 32'h1);
      take_exc(5'h05, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
      peek(5'd14, 32'hBFC0_0100, "epc held in EXL");
      peek(5'd13, 32'h8000_0014, "cause nested exc");
      do_eret();
      check("exl after eret", 32'(status_exl), 32'h0);
      take_exc(5'h08, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
      check("exl exc+eret", 32'(status_exl), 32'h1);
      check("epc exc+eret", epc, 32'h300);
      peek(5'd13, 32'h0000_0020, "cause exc+eret");

      // Hardware interrupts and software IP bits.
      do_eret();
      mtc0(5'd12, 32'h0000_FF01);
      hw_interrupt = 2'b10;
      #1;
      check("hw pending not yet", 32'(interrupt_pending), 32'h0);
      step();
      peek(5'd13, 32'h0000_0820, "cause hw IP3");
      check("hw pending", 32'(interrupt_pending), 32'h1);
      hw_interrupt = 2'b11;
      mtc0(5'd13, 32'hFFFF_FFFF);
      peek(5'd13, 32'h0000_0F20, "cause sw IP write");
      hw_interrupt = 2'b00;
      mtc0(5'd13, 32'h0);
      mtc0(5'd8, 32'hDEAD_BEEF);
      peek(5'd8, 32'h13, "badvaddr read-only");
      mtc0(5'd15, 32'h1234_5678);

      // Count wrap and write-vs-increment.
      mtc0(5'd11, 32'h0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      peek(5'd9, 32'hFFFF_FFFF, "count loaded");
      step(); step();
      peek(5'd9, 32'h0, "count wrapped");
      peek(5'd13, 32'h4000_8020, "cause TI on wrap");
      check("pending TI wrap", 32'(interrupt_pending), 32'h1);
      mtc0(5'd9, 32'h100);
      step();
      mtc0(5'd9, 32'h200);
      peek(5'd9, 32'h200, "count write beats tick");
      step();
      peek(5'd9, 32'h200, "count tick restart");
      step();
      peek(5'd9, 32'h201, "count after restart");

      for (int i = 0; i < 40; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
